pd_job_sequencer: RTL and testbench

- Bus-master controller that runs one complete job on the codeword-matching peripheral over the peripheral's host bus.
- Per job: loads WRDS codewords (pointer write, then data write, per word), then writes the control register with int_enable=1, running=1 and the job's ctr value.
- Then waits for the interrupt or a timeout, reads the status register, and returns a result record.
- Sits between a job producer (valid/ready) and one peripheral instance; it is the only master on that peripheral's bus.

---
 rtl/pd_pkg.sv | 41 ++++
 rtl/pd_wait_timer.sv | 54 +++++
 rtl/pd_job_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_pd_job_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared constants, state encoding and control-word helper for the
// codeword-matching peripheral job sequencer.
`default_nettype none

package pd_pkg;

  localparam int unsigned WRDS_DEF = 4;

  localparam logic [4:0] ADDR_DATA = 5'd0;
  localparam logic [4:0] ADDR_PTR  = 5'd8;
  localparam logic [4:0] ADDR_CR   = 5'd16;
  localparam logic [4:0] ADDR_ST   = 5'd24;

  localparam int unsigned CR_RUN_BIT   = 8;
  localparam int unsigned CR_IEN_BIT   = 9;
  localparam int unsigned ST_MATCH_BIT = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PTR   = 3'd1,
    S_DATA  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_ABORT = 3'd5,
    S_READ  = 3'd6,
    S_DONE  = 3'd7
  } state_e;

  // Control word: ctr in [7:0]; run drives both running and int_enable.
  function automatic logic [31:0] cr_word(input logic [7:0] ctr, input logic run);
    logic [31:0] w;
    w             = '0;
    w[7:0]        = ctr;
    w[CR_RUN_BIT] = run;
    w[CR_IEN_BIT] = run;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pd_wait_timer.sv
// Loadable down-counter with expiry flag, plus a saturating cycle counter
// that counts every enabled cycle.
`default_nettype none

module pd_wait_timer #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CYCW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            enable_i,
  input  logic            clear_i,
  output logic            expired_o,
  output logic [CYCW-1:0] cycles_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0]   timer_q, timer_d;
  logic [CYCW-1:0] cyc_q, cyc_d;

  always_comb begin
    timer_d = timer_q;
    cyc_d   = cyc_q;
    if (load_i) begin
      timer_d = TW'(TIMEOUT);
    end else if (enable_i && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end
    if (clear_i) begin
      cyc_d = '0;
    end else if (enable_i && (cyc_q != '1)) begin
      cyc_d = cyc_q + CYCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      cyc_q   <= '0;
    end else begin
      timer_q <= timer_d;
      cyc_q   <= cyc_d;
    end
  end

  // The timer reaches zero with this cycle's decrement, so WAIT lasts exactly TIMEOUT cycles.
  assign expired_o = enable_i && (timer_q <= TW'(1));
  assign cycles_o  = cyc_q;

endmodule

`default_nettype wire

// File: rtl/pd_job_sequencer.sv
// Bus master that loads codewords into the matching peripheral, starts it,
// waits for interrupt or timeout, reads status and returns a result record.
`default_nettype none

module pd_job_sequencer
  import pd_pkg::*;
#(
  parameter int unsigned WRDS    = WRDS_DEF,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CYCW    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [32*WRDS-1:0]   job_words,
  input  logic [7:0]           job_ctr,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_matched,
  output logic                 res_timeout,
  output logic [CYCW-1:0]      res_cycles,
  output logic                 busy,
  output logic [4:0]           pd_addr,
  output logic                 pd_hwen,
  output logic                 pd_hren,
  output logic [31:0]          pd_wdata,
  input  logic [31:0]          pd_rdata,
  input  logic                 pd_interrupt
);

  localparam int unsigned IW = (WRDS > 1) ? $clog2(WRDS) : 1;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [31:0]    words_q [WRDS];
  logic [31:0]    words_d [WRDS];
  logic [7:0]     ctr_q, ctr_d;
  logic           timeout_q, timeout_d;
  logic           matched_q, matched_d;
  logic           res_valid_q, res_valid_d;
  logic           busy_q, busy_d;
  logic           hwen_q, hwen_d;
  logic           hren_q, hren_d;
  logic [4:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;

  logic           tmr_load, tmr_en, tmr_clr, tmr_expired;
  logic           rdata_unused;

  assign rdata_unused = ^{pd_rdata[31:ST_MATCH_BIT+1], pd_rdata[ST_MATCH_BIT-1:0]};

  pd_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CYCW    (CYCW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (tmr_load),
    .enable_i  (tmr_en),
    .clear_i   (tmr_clr),
    .expired_o (tmr_expired),
    .cycles_o  (res_cycles)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    words_d   = words_q;
    ctr_d     = ctr_q;
    timeout_d = timeout_q;
    matched_d = matched_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          for (int i = 0; i < int'(WRDS); i++) begin
            words_d[i] = job_words[32*i +: 32];
          end
          ctr_d     = job_ctr;
          idx_d     = '0;
          timeout_d = 1'b0;
          matched_d = 1'b0;
          tmr_clr   = 1'b1;
          state_d   = S_PTR;
        end
      end
      S_PTR:   state_d = S_DATA;
      S_DATA: begin
        if (idx_q == IW'(WRDS - 1)) begin
          state_d = S_START;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_PTR;
        end
      end
      S_START: begin
        tmr_load = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        tmr_en = 1'b1;
        // An interrupt arriving on the expiry cycle takes precedence.
        if (pd_interrupt) begin
          state_d = S_READ;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          state_d   = S_ABORT;
        end
      end
      S_ABORT: state_d = S_READ;
      S_READ: begin
        matched_d = pd_rdata[ST_MATCH_BIT];
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus and status outputs are decoded from the next state and registered.
    hwen_d      = 1'b0;
    hren_d      = 1'b0;
    addr_d      = ADDR_DATA;
    wdata_d     = '0;
    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    unique case (state_d)
      S_PTR: begin
        hwen_d  = 1'b1;
        addr_d  = ADDR_PTR;
        wdata_d = 32'(idx_d);
      end
      S_DATA: begin
        hwen_d  = 1'b1;
        addr_d  = ADDR_DATA;
        wdata_d = words_d[idx_d];
      end
      S_START: begin
        hwen_d  = 1'b1;
        addr_d  = ADDR_CR;
        wdata_d = cr_word(ctr_d, 1'b1);
      end
      S_ABORT: begin
        hwen_d  = 1'b1;
        addr_d  = ADDR_CR;
        wdata_d = cr_word(ctr_d, 1'b0);
      end
      S_READ: begin
        hren_d = 1'b1;
        addr_d = ADDR_ST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ctr_q       <= '0;
      timeout_q   <= 1'b0;
      matched_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      hwen_q      <= 1'b0;
      hren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      for (int i = 0; i < int'(WRDS); i++) words_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ctr_q       <= ctr_d;
      timeout_q   <= timeout_d;
      matched_q   <= matched_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      hwen_q      <= hwen_d;
      hren_q      <= hren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      words_q     <= words_d;
    end
  end

  // Gated by reset so that job_ready stays low while reset is held.
  assign job_ready   = (state_q == S_IDLE) && reset;
  assign res_valid   = res_valid_q;
  assign res_matched = matched_q;
  assign res_timeout = timeout_q;
  assign busy        = busy_q;
  assign pd_hwen     = hwen_q;
  assign pd_hren     = hren_q;
  assign pd_addr     = addr_q;
  assign pd_wdata    = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_pd_job_sequencer.sv
// Directed self-checking bench for pd_job_sequencer with a small peripheral model.
`default_nettype none

module tb_pd_job_sequencer;

  localparam int WRDS = 4;
  localparam int TMO  = 16;
  localparam int CYCW = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                job_valid;
  logic                job_ready;
  logic [32*WRDS-1:0]  job_words;
  logic [7:0]          job_ctr;
  logic                res_valid;
  logic                res_ready;
  logic                res_matched;
  logic                res_timeout;
  logic [CYCW-1:0]     res_cycles;
  logic                busy;
  logic [4:0]          pd_addr;
  logic                pd_hwen;
  logic                pd_hren;
  logic [31:0]         pd_wdata;
  logic [31:0]         pd_rdata;
  logic                pd_interrupt;

  always #5 clk = ~clk;

  pd_job_sequencer #(.WRDS(WRDS), .TIMEOUT(TMO), .CYCW(CYCW)) dut (
    .clk          (clk),
    .reset        (reset),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_words    (job_words),
    .job_ctr      (job_ctr),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_matched  (res_matched),
    .res_timeout  (res_timeout),
    .res_cycles   (res_cycles),
    .busy         (busy),
    .pd_addr      (pd_addr),
    .pd_hwen      (pd_hwen),
    .pd_hren      (pd_hren),
    .pd_wdata     (pd_wdata),
    .pd_rdata     (pd_rdata),
    .pd_interrupt (pd_interrupt)
  );

  // Peripheral model: counts cycles since the last CR write; interrupts from cycle irq_at.
  logic        run_m  = 1'b0;
  int          wcnt   = 0;
  int          irq_at = 0;
  logic [31:0] st_val = 32'h0;

  always @(posedge clk) begin
    if (pd_hwen && pd_addr == 5'd16) begin
      run_m <= pd_wdata[8];
      wcnt  <= 1;
    end else if (run_m) begin
      wcnt <= wcnt + 1;
    end
  end

  assign pd_interrupt = run_m && (irq_at != 0) && (wcnt >= irq_at);
  assign pd_rdata     = (pd_hren && pd_addr == 5'd24) ? st_val : 32'h0;

  logic [38:0] trace[$];
  logic        both_hi = 1'b0;

  always @(negedge clk) begin
    if (pd_hwen || pd_hren) trace.push_back({pd_hwen, pd_hren, pd_addr, pd_wdata});
    if (pd_hwen && pd_hren) both_hi <= 1'b1;
  end

  int n_pass = 0;
  int n_chk  = 0;

  function automatic logic [38:0] wr(input logic [4:0] a, input logic [31:0] d);
    return {2'b10, a, d};
  endfunction

  task automatic start_job(input logic [127:0] w, input logic [7:0] c, input int ia,
                           input logic [31:0] st);
    @(negedge clk);
    irq_at    = ia;
    st_val    = st;
    job_words = w;
    job_ctr   = c;
    job_valid = 1'b1;
    trace.delete();
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid) begin
      n_chk++;
      $display("FAIL wait_result: res_valid never rose within %0d cycles", lat);
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic check_trace(input string nm, input logic [127:0] w, input logic [7:0] c,
                             input bit abort);
    logic [38:0] e[$];
    for (int i = 0; i < WRDS; i++) begin
      e.push_back(wr(5'd8, 32'(i)));
      e.push_back(wr(5'd0, w[32*i +: 32]));
    end
    e.push_back(wr(5'd16, {22'b0, 2'b11, c}));
    if (abort) e.push_back(wr(5'd16, {24'b0, c}));
    e.push_back({2'b01, 5'd24, 32'h0});
    n_chk++;
    if (trace.size() !== e.size())
      $display("FAIL %s trace length: got %0d exp %0d", nm, trace.size(), e.size());
    else n_pass++;
    for (int i = 0; i < e.size() && i < trace.size(); i++) begin
      n_chk++;
      if (trace[i] !== e[i])
        $display("FAIL %s trace[%0d]: got %h exp %h", nm, i, trace[i], e[i]);
      else n_pass++;
    end
  endtask

  task automatic check_result(input string nm, input int lat, input int exp_lat,
                              input logic m, input logic t, input logic [15:0] cyc);
    n_chk++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d exp %0d", nm, lat, exp_lat);
    else n_pass++;
    n_chk++;
    if ({res_matched, res_timeout} !== {m, t})
      $display("FAIL %s matched/timeout: got %b%b exp %b%b", nm, res_matched, res_timeout, m, t);
    else n_pass++;
    n_chk++;
    if (res_cycles !== cyc) $display("FAIL %s res_cycles: got %0d exp %0d", nm, res_cycles, cyc);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [127:0] wa, wb;
    int lat;
    wa = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    wb = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    @(negedge clk);
    n_chk++;
    if ({busy, job_ready, res_valid, res_matched, res_timeout, pd_hwen, pd_hren,
         res_cycles, pd_addr, pd_wdata} !== '0)
      $display("FAIL reset_state: busy=%b rdy=%b rv=%b hw=%b hr=%b addr=%0d wd=%h exp all 0",
               busy, job_ready, res_valid, pd_hwen, pd_hren, pd_addr, pd_wdata);
    else n_pass++;
    reset = 1'b1;
    start_job(wa, 8'h3C, 0, 32'h0);
    repeat (5) @(negedge clk);
    n_chk++;
    if ({pd_hwen, pd_addr, pd_wdata} !== {1'b1, 5'd0, 32'hA2A2A2A2})
      $display("FAIL mid_data_idx2: got hw=%b addr=%0d wd=%h exp 1/0/a2a2a2a2",
               pd_hwen, pd_addr, pd_wdata);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({busy, job_ready, pd_hwen, pd_hren, pd_addr, pd_wdata} !== '0)
      $display("FAIL async_reset: busy=%b rdy=%b hw=%b addr=%0d wd=%h exp 0",
               busy, job_ready, pd_hwen, pd_addr, pd_wdata);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, res_valid, res_matched, res_timeout, pd_hwen, pd_hren, res_cycles,
         pd_addr, pd_wdata, job_ready} !== {{(6+CYCW+37){1'b0}}, 1'b1})
      $display("FAIL post_reset: busy=%b rv=%b hw=%b rdy=%b exp 0/0/0/1",
               busy, res_valid, pd_hwen, job_ready);
    else n_pass++;
    start_job(wb, 8'h5A, 3, 32'h0);
    wait_result(lat);
    check_trace("restart", wb, 8'h5A, 1'b0);
    check_result("restart", lat, 14, 1'b0, 1'b0, 16'd3);
    release_result();
  endtask

  task automatic test_match();
    int lat;
    start_job({4{32'hFFFFFFFF}}, 8'h05, 7, 32'h405);
    wait_result(lat);
    check_trace("match", {4{32'hFFFFFFFF}}, 8'h05, 1'b0);
    check_result("match", lat, 18, 1'b1, 1'b0, 16'd7);
    release_result();
  endtask

  task automatic test_timeout();
    int lat;
    start_job({32'h0, 32'h1, 32'h2, 32'h3}, 8'h05, 0, 32'h0);
    wait_result(lat);
    check_trace("timeout", {32'h0, 32'h1, 32'h2, 32'h3}, 8'h05, 1'b1);
    check_result("timeout", lat, 28, 1'b0, 1'b1, 16'd16);
    release_result();
  endtask

  task automatic test_irq_at_expiry();
    int lat;
    start_job({32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0}, 8'h81, TMO, 32'h400);
    wait_result(lat);
    check_trace("irq_expiry", {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0},
                8'h81, 1'b0);
    check_result("irq_expiry", lat, 27, 1'b1, 1'b0, 16'd16);
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_job({4{32'h5A5A0F0F}}, 8'h11, 2, 32'h400);
    wait_result(lat);
    check_result("hold_first", lat, 13, 1'b1, 1'b0, 16'd2);
    trace.delete();
    job_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({res_valid, res_matched, res_timeout, res_cycles, job_ready, busy} !==
          {1'b1, 1'b1, 1'b0, 16'd2, 1'b0, 1'b1})
        $display("FAIL hold[%0d]: rv=%b m=%b t=%b cyc=%0d rdy=%b busy=%b exp 1/1/0/2/0/1",
                 i, res_valid, res_matched, res_timeout, res_cycles, job_ready, busy);
      else n_pass++;
    end
    n_chk++;
    if (trace.size() !== 0) $display("FAIL hold_bus_idle: got %0d accesses exp 0", trace.size());
    else n_pass++;
    release_result();
    n_chk++;
    if ({job_ready, res_valid, busy} !== 3'b100)
      $display("FAIL after_release: rdy=%b rv=%b busy=%b exp 1/0/0", job_ready, res_valid, busy);
    else n_pass++;
    @(negedge clk);
    job_valid = 1'b0;
    n_chk++;
    if ({pd_hwen, pd_addr, pd_wdata, busy} !== {1'b1, 5'd8, 32'd0, 1'b1})
      $display("FAIL reaccept_ptr0: hw=%b addr=%0d wd=%h exp 1/8/0", pd_hwen, pd_addr, pd_wdata);
    else n_pass++;
    wait_result(lat);
    release_result();
  endtask

  task automatic test_first_cycle_irq();
    int lat;
    start_job({32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10}, 8'hFE, 1, 32'hFFFFFBFF);
    wait_result(lat);
    check_trace("first_irq", {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10},
                8'hFE, 1'b0);
    check_result("first_irq", lat, 12, 1'b0, 1'b0, 16'd1);
    release_result();
  endtask

  initial begin
    reset     = 1'b0;
    job_valid = 1'b0;
    job_words = '0;
    job_ctr   = '0;
    res_ready = 1'b0;
    test_reset();
    test_match();
    test_timeout();
    test_irq_at_expiry();
    test_back_to_back();
    test_first_cycle_irq();
    n_chk++;
    if (both_hi !== 1'b0) $display("FAIL strobe_exclusive: hwen and hren seen high together");
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
